// File: rtl/contador_varredura_m_pkg.sv
// Shared definitions for the sweep counter: sweep mode encoding and the
// direction type. The mode values match the 2-bit `modo` input.
package contador_varredura_m_pkg;

  typedef enum logic [1:0] {
    MODO_WRAP_UP   = 2'b00,
    MODO_WRAP_DOWN = 2'b01,
    MODO_BOUNCE    = 2'b10,
    MODO_ONE_SHOT  = 2'b11
  } modo_t;

  typedef enum logic {
    DIR_SOBE  = 1'b0,
    DIR_DESCE = 1'b1
  } dir_t;

endpackage

// File: rtl/contador_varredura_m.sv
// contador_varredura_m -- up/down sweep counter with runtime limits, step and mode.
// Drives sweep positions (servo/sonar) and other ranged index sequences.
//
// Ports:
//   clock    in  1   system clock, all state changes on posedge
//   zera_s   in  1   synchronous active-high reset
//   conta    in  1   advance one step this cycle
//   carrega  in  1   load valor, clamped into [lim_inf, lim_sup]
//   valor    in  N   load value
//   modo     in  2   00 wrap-up, 01 wrap-down, 10 bounce, 11 one-shot
//   lim_inf  in  N   lower limit (inclusive)
//   lim_sup  in  N   upper limit (inclusive)
//   passo    in  PW  step size, 0 behaves as 1
//   Q        out N   current count
//   direcao  out 1   0 counting up, 1 counting down
//   inicio   out 1   Q == lim_inf
//   fim      out 1   Q == lim_sup
//   meio     out 1   Q == (lim_inf + lim_sup) >> 1
//   virou    out 1   one-cycle pulse on reversal, wrap or one-shot stop
//   parado   out 1   one-shot reached its terminal limit
//   erro_cfg out 1   lim_inf > lim_sup
module contador_varredura_m
  import contador_varredura_m_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic          clock,
  input  logic          zera_s,
  input  logic          conta,
  input  logic          carrega,
  input  logic [N-1:0]  valor,
  input  logic [1:0]    modo,
  input  logic [N-1:0]  lim_inf,
  input  logic [N-1:0]  lim_sup,
  input  logic [PW-1:0] passo,
  output logic [N-1:0]  Q,
  output logic          direcao,
  output logic          inicio,
  output logic          fim,
  output logic          meio,
  output logic          virou,
  output logic          parado,
  output logic          erro_cfg
);

  // One guard bit so sums and differences never wrap through 0 or 2^N.
  localparam int W = N + 1;

  function automatic logic [N-1:0] satura(input logic [N-1:0] v,
                                          input logic [N-1:0] lo,
                                          input logic [N-1:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic logic [N-1:0] soma_sat(input logic [N-1:0] q,
                                            input logic [N-1:0] hi,
                                            input logic [W-1:0] s);
    logic [W-1:0] t;
    t = {1'b0, q} + s;
    return (t >= {1'b0, hi}) ? hi : t[N-1:0];
  endfunction

  function automatic logic [N-1:0] sub_sat(input logic [N-1:0] q,
                                           input logic [N-1:0] lo,
                                           input logic [W-1:0] s);
    logic [W-1:0] t;
    t = {1'b0, q} - s;
    return ({1'b0, q} < ({1'b0, lo} + s)) ? lo : t[N-1:0];
  endfunction

  modo_t        modo_v;
  logic [W-1:0] s;
  logic [W-1:0] soma_lim;
  logic [N-1:0] q_up, q_dn;
  logic         fora;

  logic [N-1:0] q_p0,      q_p1;
  dir_t         dir_p0,    dir_p1;
  logic         virou_p0,  virou_p1;
  logic         parado_p0, parado_p1;

  assign modo_v   = modo_t'(modo);
  assign s        = (passo == '0) ? W'(1) : W'(passo);
  assign soma_lim = {1'b0, lim_inf} + {1'b0, lim_sup};
  assign q_up     = soma_sat(q_p1, lim_sup, s);
  assign q_dn     = sub_sat(q_p1, lim_inf, s);
  assign fora     = (q_p1 < lim_inf) || (q_p1 > lim_sup);

  // Stage p0: next-state selection, priority erro_cfg > carrega > parado > conta
  always_comb begin
    q_p0      = q_p1;
    dir_p0    = dir_p1;
    virou_p0  = 1'b0;
    parado_p0 = parado_p1;
    if (erro_cfg) begin
      q_p0 = q_p1;
    end else if (carrega) begin
      q_p0      = satura(valor, lim_inf, lim_sup);
      parado_p0 = 1'b0;
    end else if (parado_p1) begin
      // A stopped one-shot only releases when the mode moves away from it.
      if (modo_v != MODO_ONE_SHOT) parado_p0 = 1'b0;
    end else if (conta) begin
      if (modo_v == MODO_WRAP_UP)   dir_p0 = DIR_SOBE;
      if (modo_v == MODO_WRAP_DOWN) dir_p0 = DIR_DESCE;
      if (fora) begin
        // Limits moved under Q: pull it back into range without stepping.
        q_p0 = satura(q_p1, lim_inf, lim_sup);
      end else begin
        case (modo_v)
          MODO_WRAP_UP: begin
            if (q_p1 == lim_sup) begin
              q_p0     = lim_inf;
              virou_p0 = 1'b1;
            end else begin
              q_p0 = q_up;
            end
          end
          MODO_WRAP_DOWN: begin
            if (q_p1 == lim_inf) begin
              q_p0     = lim_sup;
              virou_p0 = 1'b1;
            end else begin
              q_p0 = q_dn;
            end
          end
          MODO_BOUNCE: begin
            if (dir_p1 == DIR_SOBE) begin
              if (q_p1 == lim_sup) begin
                dir_p0   = DIR_DESCE;
                q_p0     = q_dn;
                virou_p0 = 1'b1;
              end else begin
                q_p0 = q_up;
              end
            end else begin
              if (q_p1 == lim_inf) begin
                dir_p0   = DIR_SOBE;
                q_p0     = q_up;
                virou_p0 = 1'b1;
              end else begin
                q_p0 = q_dn;
              end
            end
          end
          default: begin
            q_p0 = (dir_p1 == DIR_SOBE) ? q_up : q_dn;
            if (q_p0 == ((dir_p1 == DIR_SOBE) ? lim_sup : lim_inf)) begin
              parado_p0 = 1'b1;
              virou_p0  = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Stage p1: architectural state
  always_ff @(posedge clock) begin
    if (zera_s) begin
      q_p1      <= '0;
      dir_p1    <= (modo_v == MODO_WRAP_DOWN) ? DIR_DESCE : DIR_SOBE;
      virou_p1  <= 1'b0;
      parado_p1 <= 1'b0;
    end else begin
      q_p1      <= q_p0;
      dir_p1    <= dir_p0;
      virou_p1  <= virou_p0;
      parado_p1 <= parado_p0;
    end
  end

  assign Q        = q_p1;
  assign direcao  = dir_p1;
  assign virou    = virou_p1;
  assign parado   = parado_p1;
  assign inicio   = (q_p1 == lim_inf);
  assign fim      = (q_p1 == lim_sup);
  assign meio     = ((soma_lim >> 1) == {1'b0, q_p1});
  assign erro_cfg = (lim_inf > lim_sup);

endmodule

// File: tb/tb_contador_varredura_m.sv
// Testbench for contador_varredura_m: directed sweep scenarios plus random
// traffic, each cycle compared against an integer reference model.
module tb_contador_varredura_m;

  localparam int N  = 8;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          zera_s, conta, carrega;
  logic [N-1:0]  valor, lim_inf, lim_sup;
  logic [1:0]    modo;
  logic [PW-1:0] passo;
  logic [N-1:0]  Q;
  logic          direcao, inicio, fim, meio, virou, parado, erro_cfg;

  int checks = 0;
  int errors = 0;

  // reference model state
  int mq, mdir, mvir, mpar;

  contador_varredura_m #(.N(N), .PW(PW)) dut (
    .clock(clock), .zera_s(zera_s), .conta(conta), .carrega(carrega),
    .valor(valor), .modo(modo), .lim_inf(lim_inf), .lim_sup(lim_sup),
    .passo(passo), .Q(Q), .direcao(direcao), .inicio(inicio), .fim(fim),
    .meio(meio), .virou(virou), .parado(parado), .erro_cfg(erro_cfg)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic verifica(input string tag, input int obs, input int esp);
    checks++;
    if (obs != esp) begin
      errors++;
      $display("FAIL %s obs=%0d esp=%0d t=%0t", tag, obs, esp, $time);
    end
  endtask

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  // Behavioural model of one clock edge, in plain integer arithmetic.
  task automatic modelo();
    int li, ls, s, m, alvo;
    li = lim_inf; ls = lim_sup; m = modo;
    s = (passo == 0) ? 1 : int'(passo);
    mvir = 0;
    if (zera_s) begin
      mq = 0; mdir = (m == 1) ? 1 : 0; mpar = 0;
      return;
    end
    if (li > ls) return;
    if (carrega) begin
      mq = imin(imax(int'(valor), li), ls);
      mpar = 0;
      return;
    end
    if (mpar != 0) begin
      if (m != 3) mpar = 0;
      return;
    end
    if (!conta) return;
    if (m == 0) mdir = 0;
    if (m == 1) mdir = 1;
    if (mq < li || mq > ls) begin
      mq = imin(imax(mq, li), ls);
      return;
    end
    case (m)
      0: if (mq == ls) begin mq = li; mvir = 1; end else mq = imin(mq + s, ls);
      1: if (mq == li) begin mq = ls; mvir = 1; end else mq = imax(mq - s, li);
      2: begin
        if (mdir == 0) begin
          if (mq == ls) begin mdir = 1; mq = imax(ls - s, li); mvir = 1; end
          else mq = imin(mq + s, ls);
        end else begin
          if (mq == li) begin mdir = 0; mq = imin(li + s, ls); mvir = 1; end
          else mq = imax(mq - s, li);
        end
      end
      default: begin
        alvo = (mdir == 0) ? imin(mq + s, ls) : imax(mq - s, li);
        mq = alvo;
        if (alvo == ((mdir == 0) ? ls : li)) begin mpar = 1; mvir = 1; end
      end
    endcase
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic ciclo();
    int li, ls;
    @(posedge clock);
    modelo();
    #1;
    li = lim_inf; ls = lim_sup;
    verifica("Q", int'(Q), mq);
    verifica("direcao", int'(direcao), mdir);
    verifica("virou", int'(virou), mvir);
    verifica("parado", int'(parado), mpar);
    verifica("inicio", int'(inicio), int'(mq == li));
    verifica("fim", int'(fim), int'(mq == ls));
    verifica("meio", int'(meio), int'(((li + ls) / 2) == mq));
    verifica("erro_cfg", int'(erro_cfg), int'(li > ls));
  endtask

  task automatic idle_inputs();
    zera_s = 0; conta = 0; carrega = 0;
  endtask

  task automatic carrega_valor(input int v);
    idle_inputs(); carrega = 1; valor = N'(v);
    ciclo();
    carrega = 0;
  endtask

  int seq1 [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  int vir1 [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int seq2 [4]  = '{14, 18, 20, 10};
  int seq3 [3]  = '{3, 6, 7};

  initial begin
    zera_s = 1; conta = 0; carrega = 0; valor = '0;
    modo = 2'b10; lim_inf = 0; lim_sup = 5; passo = 1;
    ciclo();
    verifica("reset_Q", int'(Q), 0);
    verifica("reset_virou", int'(virou), 0);
    verifica("reset_parado", int'(parado), 0);

    // 1: bounce 0..5
    idle_inputs(); conta = 1;
    for (int i = 0; i < 11; i++) begin
      ciclo();
      verifica("bounce_Q", int'(Q), seq1[i]);
      verifica("bounce_virou", int'(virou), vir1[i]);
    end

    // 2: wrap-up 10..20 step 4
    modo = 2'b00; lim_inf = 10; lim_sup = 20; passo = 4;
    carrega_valor(10);
    conta = 1;
    for (int i = 0; i < 4; i++) begin
      ciclo();
      verifica("wrapup_Q", int'(Q), seq2[i]);
    end
    verifica("wrapup_virou", int'(virou), 1);
    carrega_valor(15);
    verifica("meio_15", int'(meio), 1);

    // 3: one-shot 0..7 step 3
    modo = 2'b11; lim_inf = 0; lim_sup = 7; passo = 3;
    carrega_valor(0);
    conta = 1;
    for (int i = 0; i < 3; i++) begin
      ciclo();
      verifica("oneshot_Q", int'(Q), seq3[i]);
    end
    verifica("oneshot_parado", int'(parado), 1);
    verifica("oneshot_virou", int'(virou), 1);
    ciclo();
    verifica("oneshot_hold", int'(Q), 7);
    carrega_valor(2);
    verifica("oneshot_load", int'(Q), 2);
    verifica("oneshot_release", int'(parado), 0);

    // 4: limits moved under Q, then invalid limits
    modo = 2'b10; lim_inf = 0; lim_sup = 7; passo = 1;
    carrega_valor(5);
    lim_inf = 20; lim_sup = 30; conta = 1;
    ciclo();
    verifica("clamp_Q", int'(Q), 20);
    verifica("clamp_virou", int'(virou), 0);
    lim_inf = 40;
    ciclo();
    verifica("cfg_erro", int'(erro_cfg), 1);
    verifica("cfg_hold", int'(Q), 20);

    // 5: reset beats conta and carrega
    lim_inf = 0; lim_sup = 15;
    carrega_valor(9);
    zera_s = 1; conta = 1; carrega = 1; valor = 3;
    ciclo();
    verifica("zera_Q", int'(Q), 0);
    verifica("zera_virou", int'(virou), 0);

    // 6: top of range, no overflow past 2^N-1
    modo = 2'b00; lim_inf = 250; lim_sup = 255; passo = 15;
    carrega_valor(250);
    conta = 1;
    ciclo();
    verifica("topo_Q", int'(Q), 255);
    ciclo();
    verifica("topo_wrap", int'(Q), 250);
    verifica("topo_virou", int'(virou), 1);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      int r, a, b, t;
      r = $urandom_range(0, 99);
      zera_s  = (r < 2);
      carrega = (r >= 2 && r < 8);
      valor   = N'($urandom);
      conta   = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 49) == 0) modo = 2'($urandom);
      if ($urandom_range(0, 29) == 0) passo = PW'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        if (a > b && $urandom_range(0, 9) != 0) begin t = a; a = b; b = t; end
        lim_inf = N'(a); lim_sup = N'(b);
      end
      ciclo();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
